// File: rtl/addsub_arbiter_pkg.sv
// Shared constants for the add/sub arbiter: FSM encodings, requester ids and datapath width.
package addsub_arbiter_pkg;

    localparam int ADDSUB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/addsub_arbiter_addsub.sv
// Shared AdderSubtractor: 16-bit ripple chain of full adders; sub=1 computes a + ~b + 1.
module addsub_arbiter_addsub
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = ADDSUB_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH-1:0] b_eff;
    logic             carry;

    assign b_eff = b ^ {WIDTH{sub}};

    // NOTE: blocking assignments are correct here; carry is a combinational ripple
    // variable updated bit by bit within one evaluation of the block.
    always_comb begin
        s     = '0;
        carry = sub;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]  = a[i] ^ b_eff[i] ^ carry;
            carry = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit between two requesters.
// Define ADDSUB_OVF_FLAG_EN to register a signed-overflow flag on V; otherwise V is tied low.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH         = ADDSUB_W,
    parameter int PRIORITY_INIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic             AddLSubH0,
    input  logic             AddLSubH1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             Done0,
    output logic             Done1,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V,
    output logic             Busy
);

    state_t           state;
    state_t           next_state;
    logic             ptr;
    logic             grant;
    logic             winner;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             req_id;

    logic [WIDTH-1:0] sum;
    logic             carry;

    // Unit sees only the operand registers, never the live request inputs.
    addsub_arbiter_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (op_a),
        .b   (op_b),
        .sub (op_sub),
        .s   (sum),
        .co  (carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= (PRIORITY_INIT != 0);
        end else begin
            state <= next_state;
            if (grant) ptr <= ~ptr;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = IDLE;
        grant      = 1'b0;
        winner     = ptr;
        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    grant      = 1'b1;
                    next_state = EXEC;
                    if (!(Req0 && Req1)) winner = Req1 ? REQ1 : REQ0;
                end
            end
            EXEC:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reset gates the pulses so an aborted operation never reports a grant or done.
    always_comb begin
        Gnt0  = 1'b0;
        Gnt1  = 1'b0;
        Done0 = 1'b0;
        Done1 = 1'b0;
        Busy  = 1'b0;
        if (!reset) begin
            Gnt0  = grant && (winner == REQ0);
            Gnt1  = grant && (winner == REQ1);
            Done0 = (state == DONE) && (req_id == REQ0);
            Done1 = (state == DONE) && (req_id == REQ1);
            Busy  = (state == EXEC) || (state == DONE);
        end
    end

    // NOTE: operand registers are reset too, so the unit never computes on X after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
            req_id <= REQ0;
            S      <= '0;
            Co     <= 1'b0;
        end else begin
            if (grant) begin
                op_a   <= (winner == REQ1) ? A1 : A0;
                op_b   <= (winner == REQ1) ? B1 : B0;
                op_sub <= (winner == REQ1) ? AddLSubH1 : AddLSubH0;
                req_id <= winner;
            end
            if (state == EXEC) begin
                S  <= sum;
                Co <= carry;
            end
        end
    end

`ifdef ADDSUB_OVF_FLAG_EN
    logic ovf;

    // Subtract flips the operand-sign test since B enters the adder inverted.
    assign ovf = (op_sub ? (op_a[WIDTH-1] != op_b[WIDTH-1])
                         : (op_a[WIDTH-1] == op_b[WIDTH-1]))
                 && (sum[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) V <= 1'b0;
        else if (state == EXEC) V <= ovf;
    end
`else
    assign V = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed vectors, queue of expected grants/results.
module tb_addsub_arbiter;

`ifdef ADDSUB_OVF_FLAG_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic        id;
        logic [15:0] s;
        logic        co;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req0, Req1;
    logic [15:0] A0, B0, A1, B1;
    logic        AddLSubH0, AddLSubH1;
    logic        Gnt0, Gnt1, Done0, Done1;
    logic [15:0] S;
    logic        Co, V, Busy;

    exp_t exp_q[$];
    logic gnt_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_gnt_cyc = -100;
    exp_t mon_e;
    logic mon_g;

    addsub_arbiter #(.WIDTH(16), .PRIORITY_INIT(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .Req0      (Req0),
        .Req1      (Req1),
        .A0        (A0),
        .B0        (B0),
        .A1        (A1),
        .B1        (B1),
        .AddLSubH0 (AddLSubH0),
        .AddLSubH1 (AddLSubH1),
        .Gnt0      (Gnt0),
        .Gnt1      (Gnt1),
        .Done0     (Done0),
        .Done1     (Done1),
        .S         (S),
        .Co        (Co),
        .V         (V),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops expected grants/results whenever the DUT pulses Gnt or Done.
    always @(negedge clk) begin
        if (!reset) begin
            if (Gnt0 || Gnt1) begin
                check("gnt_onehot", {31'd0, Gnt0 && Gnt1}, 32'd0);
                check("gnt_expected", {31'd0, gnt_q.size() != 0}, 32'd1);
                if (gnt_q.size() != 0) begin
                    mon_g = gnt_q.pop_front();
                    check("gnt_order", {31'd0, Gnt1}, {31'd0, mon_g});
                end
                last_gnt_cyc = cyc;
            end
            if (Done0 || Done1) begin
                check("done_onehot", {31'd0, Done0 && Done1}, 32'd0);
                check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                check("done_latency", cyc - last_gnt_cyc, 32'd2);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("done_id", {31'd0, Done1}, {31'd0, mon_e.id});
                    check("result_s", {16'd0, S}, {16'd0, mon_e.s});
                    check("result_co", {31'd0, Co}, {31'd0, mon_e.co});
                    check("result_v", {31'd0, V}, {31'd0, mon_e.v});
                end
            end
        end
    end

    // Issue one request; operands are scrambled right after the grant cycle.
    task automatic do_req(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] es, input logic eco,
                          input logic ev);
        logic seen;
        exp_t e;
        e.id = id; e.s = es; e.co = eco; e.v = ev;
        exp_q.push_back(e);
        gnt_q.push_back(id);
        @(posedge clk); #1;
        if (id) begin Req1 = 1'b1; A1 = a; B1 = b; AddLSubH1 = sub; end
        else    begin Req0 = 1'b1; A0 = a; B0 = b; AddLSubH0 = sub; end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = id ? Gnt1 : Gnt0;
        end
        check("gnt_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        Req0 = 1'b0; Req1 = 1'b0;
        A0 = 16'hDEAD; B0 = 16'hBEEF; A1 = 16'hDEAD; B1 = 16'hBEEF;
        AddLSubH0 = ~sub; AddLSubH1 = ~sub;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1;
        Req0 = 1'b1; Req1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        AddLSubH0 = 1'b0; AddLSubH1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s", {16'd0, S}, 32'd0);
        check("rst_co", {31'd0, Co}, 32'd0);
        check("rst_v", {31'd0, V}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_gnt0", {31'd0, Gnt0}, 32'd0);
        check("rst_done", {30'd0, Done0, Done1}, 32'd0);
        @(posedge clk); #1;
        Req0 = 1'b0;
        reset = 1'b0;

        // Basic add/sub, carry and overflow vectors.
        do_req(1'b0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);
        do_req(1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_req(1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
        do_req(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_req(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON);
        do_req(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_ON);
        @(negedge clk);
        check("s_hold", {16'd0, S}, 32'h7FFF);

        // Contention from reset release: grants must alternate 0,1,0,1.
        @(posedge clk); #1;
        reset = 1'b1;
        Req0 = 1'b1; Req1 = 1'b1;
        A0 = 16'h0010; B0 = 16'h0001; AddLSubH0 = 1'b0;
        A1 = 16'h0020; B1 = 16'h0002; AddLSubH1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gnt_q.push_back(k[0]);
            if (k[0]) exp_q.push_back('{id: 1'b1, s: 16'h001E, co: 1'b1, v: 1'b0});
            else      exp_q.push_back('{id: 1'b0, s: 16'h0011, co: 1'b0, v: 1'b0});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (2) @(posedge clk);
        check("contention_drained", exp_q.size() + gnt_q.size(), 32'd0);

        // Abort in EXEC: no Done, outputs cleared, pointer back to requester 0.
        @(posedge clk); #1;
        gnt_q.push_back(1'b0);
        Req0 = 1'b1; A0 = 16'h1234; B0 = 16'h1111; AddLSubH0 = 1'b0;
        @(negedge clk);
        check("abort_gnt", {31'd0, Gnt0}, 32'd1);
        @(posedge clk); #1;
        Req0 = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_s", {16'd0, S}, 32'd0);
        check("abort_co", {31'd0, Co}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {30'd0, Done0, Done1}, 32'd0);
        Req0 = 1'b1; Req1 = 1'b1;
        A0 = 16'h0100; B0 = 16'h0023; AddLSubH0 = 1'b0;
        A1 = 16'h0200; B1 = 16'h0001; AddLSubH1 = 1'b0;
        gnt_q.push_back(1'b0);
        exp_q.push_back('{id: 1'b0, s: 16'h0123, co: 1'b0, v: 1'b0});
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_gnt0", {30'd0, Gnt0, Gnt1}, 32'd2);
        @(posedge clk); #1;
        Req0 = 1'b0; Req1 = 1'b0;
        A0 = 16'hDEAD; B0 = 16'hBEEF;
        repeat (4) @(posedge clk);

        @(negedge clk);
        check("queues_empty", exp_q.size() + gnt_q.size(), 32'd0);
        check("idle_busy", {31'd0, Busy}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 16-bit AdderSubtractor unit between two requesters using round-robin arbitration.
- Captures the winner's operands and operation, runs the shared unit from registered inputs, then returns a registered result with a one-cycle done pulse to that requester.
- Sits between two datapath clients (e.g. ALU stage and address/loop-counter logic) and the single add/sub resource.

Parameters:
- WIDTH, 16, operand/result width; must equal the shared unit width (16).
- PRIORITY_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- Req0, Req1  input  1 each  level request from requester 0/1.
- A0, B0, A1, B1  input  WIDTH each  operands per requester.
- AddLSubH0, AddLSubH1  input  1 each  0 = A+B, 1 = A-B.
- Gnt0, Gnt1  output  1 each  one-cycle pulse when the request is accepted.
- Done0, Done1  output  1 each  one-cycle pulse when S/Co/V are valid for that requester.
- S  output  WIDTH  registered result.
- Co  output  1  registered carry-out (subtract: 1 = no borrow).
- V  output  1  registered signed overflow (see Optional Feature).
- Busy  output  1  high while an operation is in flight.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset: state=IDLE; Gnt*, Done*, Busy, S, Co, V = 0; priority pointer = PRIORITY_INIT.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the pointer's requester.
  - On grant: pulse Gnt for 1 cycle, latch A, B and AddLSubH into operand registers, latch the requester id, toggle the pointer to the other requester, go to EXEC.
- EXEC:
  - Shared unit is driven only from the operand registers; combinational inputs never feed it directly.
  - Capture S, Co, V into the result registers; go to DONE.
- DONE:
  - Pulse Done of the latched requester for 1 cycle; go to IDLE.
- Busy = 1 in EXEC and DONE.
- Latency: Gnt at cycle N, Done at N+2. S/Co/V are valid from N+2 and hold until the next EXEC capture.
- Throughput: at most one operation per 3 cycles.
- Req is sampled only in IDLE. Operands need only be stable in the grant cycle.
  - Req held high after Done is a new request in the next IDLE cycle.
  - Req dropped while Busy has no effect on the operation in flight.
- Fairness: with both requests held continuously, grants strictly alternate 0,1,0,1…; the pointer toggles on every grant.
- Arithmetic:
  - Add: S = (A+B) mod 2^16, Co = carry out of bit 15.
  - Subtract: two's complement, S = A + ~B + 1, Co = carry out.
- Reset asserted in any state aborts the operation.
  - No Done is issued for it; outputs return to reset values on the next edge.
  - The pointer returns to PRIORITY_INIT.
- Illegal state encoding: return to IDLE.

Optional Feature:
- Macro: ADDSUB_OVF_FLAG_EN.
- Defined: V = signed overflow of the captured operation.
  - Add: A[15]==B[15] and S[15]!=A[15].
  - Subtract: A[15]!=B[15] and S[15]!=A[15].
  - V is registered with S.
- Undefined: V is tied to 0 and no overflow logic is synthesized; the port list is unchanged.

Decomposition:
- Shared package:
  - FSM state encodings (IDLE=2'd0, EXEC=2'd1, DONE=2'd2).
  - Requester id constants REQ0/REQ1.
  - Width constant ADDSUB_W=16.
- One sub-module: the existing AdderSubtractor (16-bit, FA16-based), instantiated once.
- Arbitration, FSM and result registers stay in addsub_arbiter.

Test Plan:
- Add: Req0 only, A0=0x0005, B0=0x0003, AddLSubH0=0 → Gnt0 at N, Done0 at N+2, S=0x0008, Co=0, V=0.
- Subtract: Req1 only, A1=0x0003, B1=0x0005, sub → S=0xFFFE, Co=0. Then A1=0x0005, B1=0x0003 → S=0x0002, Co=1.
- Contention: PRIORITY_INIT=0, Req0 and Req1 held high from reset release for 12 cycles.
  - Expected order: Gnt0, Gnt1, Gnt0, Gnt1.
  - Done pulses 2 cycles after each grant.
  - Never more than one Gnt or Done high in a cycle.
- Overflow (ADDSUB_OVF_FLAG_EN defined): 0x7FFF+0x0001 → S=0x8000, V=1; 0x8000-0x0001 → S=0x7FFF, V=1, Co=1.
  - Macro undefined: V=0 for both.
- Reset mid-operation: assert reset during EXEC.
  - No Done pulse; S=0, Co=0, Busy=0 next cycle.
  - With both Req high after release, the PRIORITY_INIT requester is granted first.
- Operand isolation: change A0/B0 in the cycle after Gnt0 → result reflects the operands present in the grant cycle.
